i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing a simple 8-bit register pointer interface.
// Bus pins are oversampled on clk; no clock stretching, SCL is never driven.
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  // Fewer than two synchronizer stages is never safe, so clamp.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
  } state_t;

  logic [SYNC_N-1:0] r_scl_sync, r_sda_sync;
  logic              r_scl_d, r_sda_d;
  logic              w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, n_state;
  logic [7:0] r_shift, n_shift;
  logic [3:0] r_bitcnt, n_bitcnt;
  logic       r_sda_oe, n_sda_oe;
  logic       r_busy, n_busy;
  logic [7:0] r_ptr, n_ptr;
  logic [7:0] r_wdata, n_wdata;
  logic       r_wr, n_wr;
  logic       r_inc, n_inc;
  logic       r_rw, n_rw;
  logic       r_first, n_first;

  // Input synchronizers plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_N-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_N-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_N-1];
  assign w_sda      = r_sda_sync[SYNC_N-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & ~r_sda_d & w_sda;

  // Protocol state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_ptr    <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_inc    <= 1'b0;
      r_rw     <= 1'b0;
      r_first  <= 1'b0;
    end else begin
      r_state  <= n_state;
      r_shift  <= n_shift;
      r_bitcnt <= n_bitcnt;
      r_sda_oe <= n_sda_oe;
      r_busy   <= n_busy;
      r_ptr    <= n_ptr;
      r_wdata  <= n_wdata;
      r_wr     <= n_wr;
      r_inc    <= n_inc;
      r_rw     <= n_rw;
      r_first  <= n_first;
    end
  end

  // Next-state and output decode; START/STOP override any bus-bit activity.
  always_comb begin
    n_state  = r_state;
    n_shift  = r_shift;
    n_bitcnt = r_bitcnt;
    n_sda_oe = r_sda_oe;
    n_busy   = r_busy;
    n_ptr    = r_ptr;
    n_wdata  = r_wdata;
    n_wr     = 1'b0;
    n_inc    = 1'b0;
    n_rw     = r_rw;
    n_first  = r_first;

    // Pointer advances the clock after the write strobe so reg_addr is
    // stable for the whole strobe.
    if (r_inc) n_ptr = r_ptr + 8'd1;

    if (w_start) begin
      n_state  = S_ADDR;
      n_bitcnt = '0;
      n_sda_oe = 1'b0;
      n_busy   = 1'b0;
    end else if (w_stop) begin
      n_state  = S_IDLE;
      n_sda_oe = 1'b0;
      n_busy   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_WR_BYTE: begin
          if (w_scl_rise && r_bitcnt != 4'd8) begin
            n_shift  = {r_shift[6:0], w_sda};
            n_bitcnt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == TARGET_ADDR) begin
                n_sda_oe = 1'b1;
                n_busy   = 1'b1;
                n_rw     = r_shift[0];
                n_state  = S_ADDR_ACK;
              end else begin
                n_state = S_IDLE;
              end
            end else begin
              n_sda_oe = 1'b1;
              n_state  = S_WR_ACK;
              if (r_first) begin
                n_ptr = r_shift;
              end else begin
                n_wr    = 1'b1;
                n_wdata = r_shift;
                n_inc   = 1'b1;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            n_bitcnt = '0;
            if (r_rw) begin
              n_shift  = reg_rdata;
              n_sda_oe = ~reg_rdata[7];
              n_state  = S_RD_BYTE;
            end else begin
              n_sda_oe = 1'b0;
              n_first  = 1'b1;
              n_state  = S_WR_BYTE;
            end
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            n_sda_oe = 1'b0;
            n_first  = 1'b0;
            n_bitcnt = '0;
            n_state  = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (w_scl_rise && r_bitcnt != 4'd8) begin
            n_bitcnt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              n_sda_oe = 1'b0;
              n_state  = S_RD_ACK;
            end else begin
              n_sda_oe = ~r_shift[6];
              n_shift  = {r_shift[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              n_state = S_IDLE;
              n_busy  = 1'b0;
            end else begin
              n_ptr = r_ptr + 8'd1;
            end
          end else if (w_scl_fall) begin
            n_shift  = reg_rdata;
            n_sda_oe = ~reg_rdata[7];
            n_bitcnt = '0;
            n_state  = S_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign reg_addr  = r_ptr;
  assign reg_wdata = r_wdata;
  assign reg_wr    = r_wr;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master, open-drain SDA model.
module tb_i2c_target_regs;

  localparam int unsigned T = 8;  // clocks per SCL phase

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl, m_sda;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, busy;

  logic [7:0]  mem [256];
  logic [15:0] wlog [$];
  int          oe_cnt = 0;
  int          busy_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign scl_in    = m_scl;
  assign sda_in    = m_sda & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  always @(negedge clk) begin
    if (reg_wr) wlog.push_back({reg_addr, reg_wdata});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    m_sda = b; clks(T);
    m_scl = 1'b1; clks(T);
    r = sda_in;
    m_scl = 1'b0; clks(T);
  endtask

  task automatic i2c_start;
    m_sda = 1'b0; clks(T);
    m_scl = 1'b0; clks(T);
  endtask

  task automatic i2c_rstart;
    m_sda = 1'b1; clks(T);
    m_scl = 1'b1; clks(T);
    m_sda = 1'b0; clks(T);
    m_scl = 1'b0; clks(T);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; clks(T);
    m_scl = 1'b1; clks(T);
    m_sda = 1'b1; clks(T);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic m_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(~m_ack, r);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    int         n0, oe0, busy0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    mem[8'h40] = 8'h00;

    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    clks(4);
    reset = 1'b0;
    clks(2);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_reg_wdata", reg_wdata, 8'h00);

    // Write: pointer 0x10, data 0x55, 0xAA
    i2c_start;
    wr_byte(8'hA0, ack); chk("wr_addr_ack", ack, 1);
    chk("wr_busy", busy, 1);
    wr_byte(8'h10, ack); chk("wr_ptr_ack", ack, 1);
    wr_byte(8'h55, ack); chk("wr_d1_ack", ack, 1);
    wr_byte(8'hAA, ack); chk("wr_d2_ack", ack, 1);
    i2c_stop;
    chk("wr_count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("wr_first", wlog[0], 16'h1055);
      chk("wr_second", wlog[1], 16'h11AA);
    end
    chk("wr_ptr_end", reg_addr, 8'h12);
    chk("wr_busy_stop", busy, 0);
    chk("wr_sda_oe_stop", sda_oe, 0);

    // Random read from 0x20 with repeated START
    n0 = wlog.size();
    i2c_start;
    wr_byte(8'hA0, ack); chk("rd_waddr_ack", ack, 1);
    wr_byte(8'h20, ack); chk("rd_ptr_ack", ack, 1);
    i2c_rstart;
    wr_byte(8'hA1, ack); chk("rd_raddr_ack", ack, 1);
    rd_byte(1'b1, d);    chk("rd_byte0", d, 8'h3C);
    chk("rd_ptr_after_ack", reg_addr, 8'h21);
    rd_byte(1'b0, d);    chk("rd_byte1", d, 8'hC3);
    chk("rd_busy_nack", busy, 0);
    chk("rd_sda_oe_nack", sda_oe, 0);
    chk("rd_ptr_end", reg_addr, 8'h21);
    i2c_stop;
    chk("rd_no_writes", wlog.size(), n0);

    // Address mismatch and general call are ignored
    n0 = wlog.size(); oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start;
    wr_byte(8'hA2, ack); chk("mis_addr_nack", ack, 0);
    wr_byte(8'h00, ack); chk("mis_data_nack", ack, 0);
    i2c_stop;
    i2c_start;
    wr_byte(8'h00, ack); chk("gcall_nack", ack, 0);
    i2c_stop;
    chk("mis_no_oe", oe_cnt - oe0, 0);
    chk("mis_no_busy", busy_cnt - busy0, 0);
    chk("mis_no_writes", wlog.size(), n0);

    // Pointer wrap 0xFF -> 0x00
    n0 = wlog.size();
    i2c_start;
    wr_byte(8'hA0, ack); chk("wrap_addr_ack", ack, 1);
    wr_byte(8'hFF, ack); chk("wrap_ptr_ack", ack, 1);
    wr_byte(8'h01, ack); chk("wrap_d1_ack", ack, 1);
    wr_byte(8'h02, ack); chk("wrap_d2_ack", ack, 1);
    i2c_stop;
    chk("wrap_count", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) begin
      chk("wrap_first", wlog[n0], 16'hFF01);
      chk("wrap_second", wlog[n0+1], 16'h0002);
    end
    chk("wrap_ptr_end", reg_addr, 8'h01);

    // Reset while driving a read bit, then bus traffic without START
    i2c_start;
    wr_byte(8'hA0, ack); chk("rr_waddr_ack", ack, 1);
    wr_byte(8'h40, ack); chk("rr_ptr_ack", ack, 1);
    i2c_rstart;
    wr_byte(8'hA1, ack); chk("rr_raddr_ack", ack, 1);
    chk("rr_driving", sda_oe, 1);
    reset = 1'b1; clks(1);
    reset = 1'b0;
    chk("rr_released", sda_oe, 0);
    chk("rr_ptr_reset", reg_addr, 8'h00);
    n0 = wlog.size(); oe0 = oe_cnt; busy0 = busy_cnt;
    wr_byte(8'hA0, ack); chk("rr_no_ack", ack, 0);
    for (int i = 0; i < 9; i++) i2c_bit(1'b1, r);
    chk("rr_no_oe", oe_cnt - oe0, 0);
    chk("rr_no_busy", busy_cnt - busy0, 0);
    chk("rr_no_writes", wlog.size(), n0);
    i2c_stop;

    // STOP after three data bits aborts the byte
    i2c_start;
    wr_byte(8'hA0, ack); chk("ab_addr_ack", ack, 1);
    wr_byte(8'h30, ack); chk("ab_ptr_ack", ack, 1);
    n0 = wlog.size();
    i2c_bit(1'b1, r);
    i2c_bit(1'b0, r);
    i2c_bit(1'b1, r);
    i2c_stop;
    clks(4);
    chk("ab_no_writes", wlog.size(), n0);
    chk("ab_ptr", reg_addr, 8'h30);
    chk("ab_busy", busy, 0);
    chk("ab_sda_oe", sda_oe, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
